// File: rtl/serial_arith_pkg.sv
// Shared definitions for the bit-serial adder/subtractor engines:
// FSM state encoding, default operand width and counter sizing.
package serial_arith_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

  localparam int DEFAULT_WIDTH = 8;

  // Counter must hold 0..w inclusive.
  function automatic int cnt_width(input int w);
    return $clog2(w + 1);
  endfunction

endpackage

// File: rtl/serial_subtractor_full_subtractor.sv
// One-bit full subtractor cell: diff = x - y - bin, with borrow-out.
module full_subtractor (
  input  logic x,
  input  logic y,
  input  logic bin,
  output logic diff,
  output logic bout
);

  assign diff = x ^ y ^ bin;
  assign bout = (~x & y) | (~(x ^ y) & bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial two's-complement subtractor, d = a - b, LSB first through one
// full-subtractor cell; start/done handshake shared with the serial adder.
module serial_subtractor
  import serial_arith_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] d,
  output logic             borrow,
  output logic             zero,
  output logic             busy,
  output logic             done
);

  localparam int CW = cnt_width(WIDTH);
  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  state_e           state_q;
  logic [WIDTH-1:0] ah_q;
  logic [WIDTH-1:0] bh_q;
  logic [WIDTH-1:0] acc_q;
  logic             br_q;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] d_q;
  logic             borrow_q;
  logic             zero_q;
  logic             busy_q;
  logic             done_q;

  logic             diff_s;
  logic             bout_s;
  logic [WIDTH-1:0] acc_nxt_s;

  full_subtractor u_cell (
    .x    (ah_q[0]),
    .y    (bh_q[0]),
    .bin  (br_q),
    .diff (diff_s),
    .bout (bout_s)
  );

  // New difference bit enters at the MSB so that after WIDTH shifts the
  // accumulator holds the result in natural bit order.
  assign acc_nxt_s = {diff_s, acc_q[WIDTH-1:1]};

  // FSM, counter, operand shift registers and registered result outputs.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= IDLE;
      ah_q     <= '0;
      bh_q     <= '0;
      acc_q    <= '0;
      br_q     <= 1'b0;
      cnt_q    <= '0;
      d_q      <= '0;
      borrow_q <= 1'b0;
      zero_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          if (start) begin
            ah_q    <= a;
            bh_q    <= b;
            acc_q   <= '0;
            br_q    <= 1'b0;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= SHIFT;
          end else begin
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end
        end
        SHIFT: begin
          ah_q  <= ah_q >> 1;
          bh_q  <= bh_q >> 1;
          acc_q <= acc_nxt_s;
          br_q  <= bout_s;
          cnt_q <= cnt_q + CNT_ONE;
          // Last shift: publish result together with the done pulse.
          if (cnt_q == LAST_CNT) begin
            d_q      <= acc_nxt_s;
            borrow_q <= bout_s;
            zero_q   <= (acc_nxt_s == '0);
            done_q   <= 1'b1;
            busy_q   <= 1'b0;
            state_q  <= DONE;
          end else begin
            done_q   <= 1'b0;
            busy_q   <= 1'b1;
            state_q  <= SHIFT;
          end
        end
        DONE: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign d      = d_q;
  assign borrow = borrow_q;
  assign zero   = zero_q;
  assign busy   = busy_q;
  assign done   = done_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed self-checking bench for serial_subtractor (WIDTH 8 and 16).
module tb_serial_subtractor;

  logic        clk = 1'b0;
  logic        rst;
  logic        start8, start16;
  logic [7:0]  a8, b8, d8;
  logic [15:0] a16, b16, d16;
  logic        borrow8, zero8, busy8, done8;
  logic        borrow16, zero16, busy16, done16;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  serial_subtractor #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8),
    .d(d8), .borrow(borrow8), .zero(zero8), .busy(busy8), .done(done8)
  );

  serial_subtractor #(.WIDTH(16)) dut16 (
    .clk(clk), .rst(rst), .start(start16), .a(a16), .b(b16),
    .d(d16), .borrow(borrow16), .zero(zero16), .busy(busy16), .done(done16)
  );

  // Stimulus only: runs one 8-bit operation, returns latency and busy count.
  task automatic do_op8(input logic [7:0] a, input logic [7:0] b,
                        output int lat, output int bcnt);
    int guard = 0;
    while ((busy8 || done8) && guard < 40) begin
      @(negedge clk);
      guard++;
    end
    a8 = a; b8 = b; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    lat = 0; bcnt = 0;
    while (!done8 && lat < 40) begin
      if (busy8) bcnt++;
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b0; start8 = 1'b0; start16 = 1'b0;
    a8 = 8'h00; b8 = 8'h00; a16 = 16'h0000; b16 = 16'h0000;
    repeat (3) @(negedge clk);
    checks++; if (d8 !== 8'h00) begin errors++; $display("FAIL reset_d: got %h expected %h", d8, 8'h00); end
    checks++; if ({borrow8, zero8, busy8, done8} !== 4'b0000) begin errors++; $display("FAIL reset_flags: got %b expected %b", {borrow8, zero8, busy8, done8}, 4'b0000); end
    checks++; if ({d16, borrow16, zero16, busy16, done16} !== 20'h00000) begin errors++; $display("FAIL reset_w16: got %h expected %h", {d16, borrow16, zero16, busy16, done16}, 20'h00000); end
    rst = 1'b1;
    @(negedge clk);
    checks++; if ({busy8, done8} !== 2'b00) begin errors++; $display("FAIL reset_idle: got %b expected %b", {busy8, done8}, 2'b00); end
  endtask

  task automatic test_sub_basic();
    int lat, bc;
    do_op8(8'h5A, 8'h23, lat, bc);
    checks++; if (lat !== 8) begin errors++; $display("FAIL basic_latency: got %0d expected %0d", lat, 8); end
    checks++; if (bc !== 8) begin errors++; $display("FAIL basic_busy_cycles: got %0d expected %0d", bc, 8); end
    checks++; if (d8 !== 8'h37) begin errors++; $display("FAIL basic_d: got %h expected %h", d8, 8'h37); end
    checks++; if ({borrow8, zero8} !== 2'b00) begin errors++; $display("FAIL basic_flags: got %b expected %b", {borrow8, zero8}, 2'b00); end
    @(negedge clk);
    checks++; if (done8 !== 1'b0) begin errors++; $display("FAIL basic_done_width: got %b expected %b", done8, 1'b0); end
    checks++; if (d8 !== 8'h37) begin errors++; $display("FAIL basic_d_hold: got %h expected %h", d8, 8'h37); end
  endtask

  task automatic test_underflow();
    int lat, bc;
    do_op8(8'h23, 8'h5A, lat, bc);
    checks++; if (d8 !== 8'hC9) begin errors++; $display("FAIL under_d: got %h expected %h", d8, 8'hC9); end
    checks++; if ({borrow8, zero8} !== 2'b10) begin errors++; $display("FAIL under_flags: got %b expected %b", {borrow8, zero8}, 2'b10); end
    do_op8(8'h00, 8'h01, lat, bc);
    checks++; if (d8 !== 8'hFF) begin errors++; $display("FAIL under_ff_d: got %h expected %h", d8, 8'hFF); end
    checks++; if ({borrow8, zero8} !== 2'b10) begin errors++; $display("FAIL under_ff_flags: got %b expected %b", {borrow8, zero8}, 2'b10); end
  endtask

  task automatic test_zero();
    int n = 0;
    int changed = 0;
    @(negedge clk);
    a8 = 8'h7F; b8 = 8'h7F; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    while (!done8 && n < 40) begin
      if (d8 !== 8'hFF) changed++;
      @(negedge clk);
      n++;
    end
    checks++; if (changed !== 0) begin errors++; $display("FAIL zero_prev_hold: got %0d early changes expected %0d", changed, 0); end
    checks++; if (n !== 8) begin errors++; $display("FAIL zero_latency: got %0d expected %0d", n, 8); end
    checks++; if (d8 !== 8'h00) begin errors++; $display("FAIL zero_d: got %h expected %h", d8, 8'h00); end
    checks++; if ({borrow8, zero8} !== 2'b01) begin errors++; $display("FAIL zero_flags: got %b expected %b", {borrow8, zero8}, 2'b01); end
  endtask

  task automatic test_ignore_start();
    int first = -1;
    int second = -1;
    int pulses = 0;
    logic [7:0] d_first = 8'h00;
    logic [7:0] d_second = 8'h00;
    logic       b_second = 1'b1;
    @(negedge clk);
    a8 = 8'h80; b8 = 8'h01; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    for (int n = 0; n < 30; n++) begin
      if (done8) begin
        pulses++;
        if (first < 0) begin
          first = n; d_first = d8;
        end else if (second < 0) begin
          second = n; d_second = d8; b_second = borrow8;
        end
      end
      case (n)
        2:       begin start8 = 1'b1; a8 = 8'hFF; b8 = 8'h00; end
        3:       start8 = 1'b0;
        8:       begin start8 = 1'b1; a8 = 8'hFF; b8 = 8'h00; end
        10:      start8 = 1'b0;
        default: ;
      endcase
      @(negedge clk);
    end
    checks++; if (d_first !== 8'h7F) begin errors++; $display("FAIL ignore_d: got %h expected %h", d_first, 8'h7F); end
    checks++; if (first !== 8) begin errors++; $display("FAIL ignore_first_done: got %0d expected %0d", first, 8); end
    checks++; if (second - first !== 10) begin errors++; $display("FAIL ignore_done_spacing: got %0d expected %0d", second - first, 10); end
    checks++; if (pulses !== 2) begin errors++; $display("FAIL ignore_pulse_count: got %0d expected %0d", pulses, 2); end
    checks++; if ({d_second, b_second} !== 9'h1FE) begin errors++; $display("FAIL ignore_second: got %h expected %h", {d_second, b_second}, 9'h1FE); end
  endtask

  task automatic test_reset_mid();
    int lat, bc;
    int stray = 0;
    a8 = 8'h10; b8 = 8'h01; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    checks++; if (d8 !== 8'h00) begin errors++; $display("FAIL midrst_d: got %h expected %h", d8, 8'h00); end
    checks++; if ({borrow8, zero8, busy8, done8} !== 4'b0000) begin errors++; $display("FAIL midrst_flags: got %b expected %b", {borrow8, zero8, busy8, done8}, 4'b0000); end
    for (int n = 0; n < 20; n++) begin
      if (done8 || busy8) stray++;
      @(negedge clk);
    end
    checks++; if (stray !== 0) begin errors++; $display("FAIL midrst_no_done: got %0d active cycles expected %0d", stray, 0); end
    do_op8(8'h10, 8'h01, lat, bc);
    checks++; if (d8 !== 8'h0F) begin errors++; $display("FAIL midrst_rerun_d: got %h expected %h", d8, 8'h0F); end
    checks++; if ({borrow8, lat} !== {1'b0, 32'd8}) begin errors++; $display("FAIL midrst_rerun_lat: got borrow %b lat %0d expected borrow 0 lat 8", borrow8, lat); end
  endtask

  task automatic test_reset_start();
    int stray = 0;
    @(negedge clk);
    rst = 1'b0; a8 = 8'h5A; b8 = 8'h23; start8 = 1'b1;
    @(negedge clk);
    rst = 1'b1; start8 = 1'b0;
    checks++; if ({d8, busy8, done8} !== 10'h000) begin errors++; $display("FAIL rststart_out: got %h expected %h", {d8, busy8, done8}, 10'h000); end
    for (int n = 0; n < 12; n++) begin
      if (done8 || busy8) stray++;
      @(negedge clk);
    end
    checks++; if (stray !== 0) begin errors++; $display("FAIL rststart_dropped: got %0d active cycles expected %0d", stray, 0); end
  endtask

  task automatic test_width16();
    int n = 0;
    a16 = 16'h1234; b16 = 16'h4321; start16 = 1'b1;
    @(negedge clk);
    start16 = 1'b0;
    while (!done16 && n < 60) begin
      @(negedge clk);
      n++;
    end
    checks++; if (n !== 16) begin errors++; $display("FAIL w16_latency: got %0d expected %0d", n, 16); end
    checks++; if (d16 !== 16'hCF13) begin errors++; $display("FAIL w16_d: got %h expected %h", d16, 16'hCF13); end
    checks++; if ({borrow16, zero16} !== 2'b10) begin errors++; $display("FAIL w16_flags: got %b expected %b", {borrow16, zero16}, 2'b10); end
  endtask

  initial begin
    test_reset();
    test_sub_basic();
    test_underflow();
    test_zero();
    test_ignore_start();
    test_reset_mid();
    test_reset_start();
    test_width16();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
